node_rec_iter: RTL and testbench
================================

Name: node_rec_iter

Overview:
- Parametrised primitive-recursion node: y0 = IN0, then y(k+1) = step(y(k), IN1, k) for k = 0..IN2-1; the result is y(IN2).
- Successor to the fixed 16-bit generated node/root blocks. Uses the same ST/RD start/ready handshake, so it chains into generated roots unchanged: its ST is driven by an upstream RD, and its RD is ANDed into the root RD.
- Adds configurable data and count widths, a run-time step mode, and a sticky overflow flag.

Parameters:
- W, 16, data width of IN0, IN1 and RES.
- CW, 16, width of iteration count IN2 and of the internal counter k.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- ST  input  1  start level from upstream RD or the root ST.
- RD  output  1  result ready; registered.
- RES  output  W  result y(n); registered.
- OVF  output  1  sticky flag: the step wrapped or saturated at least once during the last run; registered.
- IN0  input  W  seed y0.
- IN1  input  W  step operand x.
- IN2  input  CW  iteration count n, unsigned.
- MODE  input  2  step select: 0 ADD, 1 MUL, 2 SUBS, 3 ADDK.

Behaviour:
- Reset: one clock, CLK; asynchronous active-high reset, RST.
  - RST forces state IDLE and sets RD=0, RES=0, OVF=0, y=0, k=0.
  - RST asserted mid-RUN aborts the run; RD never rises for the aborted run.
- States: IDLE, RUN, DONE.
- IDLE:
  - RD=0.
  - On an edge with ST=1: latch y=IN0, x=IN1, n=IN2, mode=MODE; set k=0, OVF=0; go to RUN.
- RUN, one iteration per edge:
  - If k==n: RES<=y, RD<=1, go to DONE.
  - Else: y <= step(y,x,k), k <= k+1, OVF <= OVF | step_ovf.
- Latency: with the start edge as e0, RD=1 becomes visible after edge e(n+1).
  - n=0 gives RES=IN0 after e1.
- DONE:
  - RD=1; RES and OVF are held.
  - On an edge with ST=0: go to IDLE with RD<=0.
  - While ST=1: remain in DONE; no restart.
- A new run requires ST to fall and then rise again.
- Inputs that change after e0 are ignored; the operands are latched.
- ST falling during RUN is ignored. The run completes and enters DONE; if ST is still 0 on the next edge, RD is high for exactly one cycle.
- Step arithmetic, all results truncated to W bits:
  - ADD: y+x; ovf = carry out of bit W-1.
  - MUL: low W bits of y*x; ovf = upper W bits nonzero.
  - SUBS: truncated subtraction, y-x if y>=x else 0; ovf = (y<x).
  - ADDK: y + zero-extended/truncated k; ovf = carry, or k wider than W with its upper bits nonzero.
- Counter:
  - k never exceeds n, so no wrap.
  - n = 2^CW-1 is legal and takes 2^CW edges.
- RES changes only on the RUN-to-DONE transition; its value is stable in IDLE between runs.

Decomposition:
- Shared package maltsev_pkg:
  - mode enum: MODE_ADD=0, MODE_MUL=1, MODE_SUBS=2, MODE_ADDK=3.
  - state enum: IDLE, RUN, DONE.
  - Default width constants W_DEF=16, CW_DEF=16.
- Sub-module rec_step_alu:
  - Combinational, parametrised W and CW.
  - Inputs y, x, k, mode; outputs next_y and step_ovf.
  - Verified standalone against the step-arithmetic rules.
- node_rec_iter holds the FSM, the operand registers and the counter.

Test Plan:
- ADD, IN0=5, IN1=3, IN2=4, ST held high → RD rises after e5, RES=17, OVF=0; RD stays 1 until ST falls, then RD=0 on the next edge.
- MUL, IN0=1, IN1=16, IN2=4 (W=16) → RES=0, OVF=1. Repeat with IN2=3 → RES=4096, OVF=0 (OVF cleared at the new start).
- SUBS, IN0=10, IN1=4, IN2=3 → RES=0, OVF=1. Same with IN2=2 → RES=2, OVF=0.
- ADDK, IN0=0, IN2=5 → RES=0+1+2+3+4=10. IN2=0 in any mode → RES=IN0 after e1.
- Operands changed mid-RUN, and ST dropped at e2 of a 4-iteration ADD run → result unaffected; RD is high for exactly one cycle.
- RST asserted mid-RUN with no clock edge (asynchronous) → RD=0, RES=0, OVF=0 immediately; the next ST starts a clean run.

Source files
------------

// File: rtl/maltsev_pkg.sv
// Shared types and default widths for the primitive-recursion node family.
package maltsev_pkg;

    localparam int W_DEF  = 16;
    localparam int CW_DEF = 16;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'd0,
        MODE_MUL  = 2'd1,
        MODE_SUBS = 2'd2,
        MODE_ADDK = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rec_step_alu.sv
// Combinational step function y(k+1) = step(y(k), x, k) with overflow detect.
module rec_step_alu
    import maltsev_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic [W-1:0]  y,
    input  logic [W-1:0]  x,
    input  logic [CW-1:0] k,
    input  mode_t         mode,
    output logic [W-1:0]  next_y,
    output logic          step_ovf
);

    // k is widened to whichever of CW/W is larger so both truncation and
    // zero-extension fall out of a single slice.
    localparam int KW = (CW > W) ? CW : W;

    logic [W:0]      sum_s;
    logic [W:0]      sumk_s;
    logic [2*W-1:0]  prod_s;
    logic [KW-1:0]   k_wide_s;
    logic            k_hi_nz_s;

    assign k_wide_s  = KW'(k);
    assign k_hi_nz_s = (k_wide_s >> W) != {KW{1'b0}};
    assign sum_s     = {1'b0, y} + {1'b0, x};
    assign sumk_s    = {1'b0, y} + {1'b0, k_wide_s[W-1:0]};
    assign prod_s    = {{W{1'b0}}, y} * {{W{1'b0}}, x};

    // Select the step result and its overflow condition by mode.
    always_comb begin
        next_y   = {W{1'b0}};
        step_ovf = 1'b0;
        case (mode)
            MODE_ADD: begin
                next_y   = sum_s[W-1:0];
                step_ovf = sum_s[W];
            end
            MODE_MUL: begin
                next_y   = prod_s[W-1:0];
                step_ovf = prod_s[2*W-1:W] != {W{1'b0}};
            end
            MODE_SUBS: begin
                if (y >= x) begin
                    next_y   = y - x;
                    step_ovf = 1'b0;
                end else begin
                    next_y   = {W{1'b0}};
                    step_ovf = 1'b1;
                end
            end
            MODE_ADDK: begin
                next_y   = sumk_s[W-1:0];
                step_ovf = sumk_s[W] | k_hi_nz_s;
            end
            default: begin
                next_y   = {W{1'b0}};
                step_ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/node_rec_iter.sv
// Primitive-recursion node: y0 = IN0, y(k+1) = step(y(k), IN1, k), result y(IN2).
// ST/RD handshake compatible with the generated node/root blocks.
module node_rec_iter
    import maltsev_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ST,
    output logic          RD,
    output logic [W-1:0]  RES,
    output logic          OVF,
    input  logic [W-1:0]  IN0,
    input  logic [W-1:0]  IN1,
    input  logic [CW-1:0] IN2,
    input  logic [1:0]    MODE
);

    state_t        state_r;
    logic [W-1:0]  y_r;
    logic [W-1:0]  x_r;
    logic [CW-1:0] n_r;
    logic [CW-1:0] k_r;
    mode_t         mode_r;
    logic [W-1:0]  res_r;
    logic          rd_r;
    logic          ovf_r;

    logic [W-1:0]  next_y_s;
    logic          step_ovf_s;

    rec_step_alu #(
        .W  (W),
        .CW (CW)
    ) u_alu (
        .y        (y_r),
        .x        (x_r),
        .k        (k_r),
        .mode     (mode_r),
        .next_y   (next_y_s),
        .step_ovf (step_ovf_s)
    );

    // Control FSM with latched operands, iteration counter and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
            y_r     <= {W{1'b0}};
            x_r     <= {W{1'b0}};
            n_r     <= {CW{1'b0}};
            k_r     <= {CW{1'b0}};
            mode_r  <= MODE_ADD;
            res_r   <= {W{1'b0}};
            rd_r    <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    rd_r <= 1'b0;
                    if (ST) begin
                        y_r     <= IN0;
                        x_r     <= IN1;
                        n_r     <= IN2;
                        mode_r  <= mode_t'(MODE);
                        k_r     <= {CW{1'b0}};
                        ovf_r   <= 1'b0;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    // k stops at n, so the counter can never wrap even for n = 2^CW-1.
                    if (k_r == n_r) begin
                        res_r   <= y_r;
                        rd_r    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        y_r   <= next_y_s;
                        k_r   <= k_r + CW'(1);
                        ovf_r <= ovf_r | step_ovf_s;
                    end
                end
                DONE: begin
                    // Holding ST high keeps the result; a restart needs ST to drop first.
                    if (!ST) begin
                        rd_r    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    rd_r    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign RD  = rd_r;
    assign RES = res_r;
    assign OVF = ovf_r;

endmodule

// File: tb/tb_node_rec_iter.sv
// Directed self-checking bench for node_rec_iter (W=16, CW=16).
module tb_node_rec_iter;

    logic        CLK;
    logic        RST;
    logic        ST;
    logic        RD;
    logic [15:0] RES;
    logic        OVF;
    logic [15:0] IN0;
    logic [15:0] IN1;
    logic [15:0] IN2;
    logic [1:0]  MODE;

    int n_total;
    int n_pass;

    node_rec_iter #(.W(16), .CW(16)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .ST   (ST),
        .RD   (RD),
        .RES  (RES),
        .OVF  (OVF),
        .IN0  (IN0),
        .IN1  (IN1),
        .IN2  (IN2),
        .MODE (MODE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Full run with ST held high: checks latency, result, hold in DONE and return to IDLE.
    task automatic run(input string tag, input logic [1:0] m, input logic [15:0] a,
                       input logic [15:0] b, input int n,
                       input logic [15:0] exp_res, input logic exp_ovf);
        @(negedge CLK);
        MODE = m; IN0 = a; IN1 = b; IN2 = 16'(n); ST = 1'b1;
        @(posedge CLK);                      // e0
        repeat (n) @(posedge CLK);           // e1..en
        @(negedge CLK);
        check({tag, "_rd_early"}, {31'd0, RD}, 32'd0);
        @(posedge CLK);                      // e(n+1)
        @(negedge CLK);
        check({tag, "_rd"},  {31'd0, RD},  32'd1);
        check({tag, "_res"}, {16'd0, RES}, {16'd0, exp_res});
        check({tag, "_ovf"}, {31'd0, OVF}, {31'd0, exp_ovf});
        repeat (2) @(negedge CLK);
        check({tag, "_rd_hold"}, {31'd0, RD}, 32'd1);
        ST = 1'b0;
        @(negedge CLK);
        check({tag, "_rd_fall"}, {31'd0, RD}, 32'd0);
        @(negedge CLK);
        check({tag, "_res_idle"}, {16'd0, RES}, {16'd0, exp_res});
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        RST = 1'b1; ST = 1'b0; IN0 = 16'd0; IN1 = 16'd0; IN2 = 16'd0; MODE = 2'd0;
        #2;
        check("rst_rd",  {31'd0, RD},  32'd0);
        check("rst_res", {16'd0, RES}, 32'd0);
        check("rst_ovf", {31'd0, OVF}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("idle_rd", {31'd0, RD}, 32'd0);

        run("add",     2'd0, 16'd5,      16'd3,  4, 16'd17,   1'b0);
        run("add_ovf", 2'd0, 16'hFFF0,   16'h20, 1, 16'h0010, 1'b1);
        run("mul4",    2'd1, 16'd1,      16'd16, 4, 16'd0,    1'b1);
        run("mul3",    2'd1, 16'd1,      16'd16, 3, 16'd4096, 1'b0);
        run("subs3",   2'd2, 16'd10,     16'd4,  3, 16'd0,    1'b1);
        run("subs2",   2'd2, 16'd10,     16'd4,  2, 16'd2,    1'b0);
        run("addk5",   2'd3, 16'd0,      16'd99, 5, 16'd10,   1'b0);
        run("n0_mul",  2'd1, 16'h1234,   16'd7,  0, 16'h1234, 1'b0);

        // Operands changed after e0 and ST dropped before e2 of a 4-iteration ADD.
        @(negedge CLK);
        MODE = 2'd0; IN0 = 16'd5; IN1 = 16'd3; IN2 = 16'd4; ST = 1'b1;
        @(posedge CLK);                      // e0
        @(negedge CLK);
        MODE = 2'd1; IN0 = 16'd100; IN1 = 16'd50; IN2 = 16'd1;
        @(posedge CLK);                      // e1
        @(negedge CLK);
        ST = 1'b0;
        repeat (3) @(posedge CLK);           // e2..e4
        @(negedge CLK);
        check("mid_rd_early", {31'd0, RD}, 32'd0);
        @(posedge CLK);                      // e5
        @(negedge CLK);
        check("mid_rd",  {31'd0, RD},  32'd1);
        check("mid_res", {16'd0, RES}, 32'd17);
        check("mid_ovf", {31'd0, OVF}, 32'd0);
        @(negedge CLK);
        check("mid_rd_pulse", {31'd0, RD}, 32'd0);
        repeat (3) @(negedge CLK);
        check("mid_no_restart", {31'd0, RD}, 32'd0);

        // Asynchronous reset mid-run after an overflowing step; RES holds 17 beforehand.
        MODE = 2'd0; IN0 = 16'hFFF0; IN1 = 16'h20; IN2 = 16'd3; ST = 1'b1;
        @(posedge CLK);                      // e0
        @(posedge CLK);                      // e1: overflow recorded
        @(negedge CLK);
        check("pre_abort_ovf", {31'd0, OVF}, 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check("abort_rd",  {31'd0, RD},  32'd0);
        check("abort_res", {16'd0, RES}, 32'd0);
        check("abort_ovf", {31'd0, OVF}, 32'd0);
        ST = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        check("abort_no_rd", {31'd0, RD}, 32'd0);

        run("post_rst", 2'd0, 16'd5, 16'd3, 4, 16'd17, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
